ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter: PC_W, 8, program-counter width in bits.
REQ-002 SHALL have parameter: TMO_CYC, 16, memory-wait timeout in cycles; used only with REQ-030.
REQ-003 SHALL have ports, one per line: name direction width meaning.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  fetch source presents an instruction.
- instr_data  input  16  instruction word: [15:12] op, [11:8] rD, [7:4] rA, [3:0] rB; [7:0] imm8 for LDI.
- instr_ready  output  1  unit accepts an instruction this cycle.
- pc  output  PC_W  address of the current instruction.
- op_code  output  4  IR[15:12], to the write-back mux.
- imm_en  output  1  high when IR op is LDI.
- imm_out  output  16  sign-extended imm8.
- sel_d, sel_a, sel_b  output  4 each  register selectors.
- reg_we  output  1  register-file write strobe.
- mem_rd_req, mem_wr_req  output  1 each  memory request.
- mem_ack  input  1  memory completion.
- halted  output  1  sticky halt flag.
- mem_err  output  1  sticky timeout flag; tied 0 when the macro in REQ-030 is absent.

Function
REQ-004 SHALL decode opcodes as: 0000 NOP, 0001 LOAD, 0010 STORE, 1000 LDI, 1111 HALT; all others are ALU ops.
REQ-005 SHALL implement the states FETCH, DECODE, MEM, WB and HALT.
REQ-006 SHALL drive instr_ready=1 only in FETCH.
REQ-007 SHALL, in FETCH, on instr_valid&&instr_ready, capture instr_data into IR and go to DECODE next cycle; otherwise stay in FETCH.
REQ-008 SHALL spend exactly one cycle in DECODE, then go to:
- MEM for LOAD/STORE;
- WB for LDI/ALU;
- HALT for HALT;
- FETCH for NOP, with pc+1.
REQ-009 SHALL, in MEM, hold mem_rd_req (LOAD) or mem_wr_req (STORE) high every cycle until mem_ack is sampled high.
REQ-010 SHALL, on mem_ack in MEM, go to WB for LOAD, or to FETCH with pc+1 for STORE; the request drops the same edge.
REQ-011 SHALL ignore mem_ack in every state except MEM.
REQ-012 SHALL assert reg_we for exactly one cycle in WB, then go to FETCH with pc+1.
REQ-013 SHALL drive op_code, imm_en, imm_out, sel_d, sel_a and sel_b from IR, stable from DECODE through the end of WB.
REQ-014 SHALL compute imm_out = {8{IR[7]}, IR[7:0]}, e.g. imm8 0x80 -> 0xFF80.
REQ-015 SHALL increment pc modulo 2^PC_W; 0xFF+1 -> 0x00 at PC_W=8.
REQ-016 SHALL, in HALT, set halted=1, keep instr_ready=0, and remain there until rst.
REQ-017 SHALL never assert reg_we together with mem_rd_req or mem_wr_req.
REQ-018 SHALL give instruction latency, from the accept edge to the return to FETCH, of:
- NOP 2 cycles;
- ALU/LDI 3 cycles;
- STORE 2+N cycles;
- LOAD 3+N cycles;
where N is the number of MEM cycles (N>=1).

Reset
REQ-019 SHALL, on rst=1 at a clock edge, set state=FETCH, pc=0, IR=0, reg_we=0, mem_rd_req=0, mem_wr_req=0, halted=0 and mem_err=0.
REQ-020 SHALL honour rst from any state, including mid-MEM; the request drops the next cycle and no reg_we is issued for the aborted instruction.
REQ-021 SHALL give rst priority over instr_valid and mem_ack sampled on the same edge.

Configuration
REQ-030 SHALL provide the macro CTRL_MEM_TIMEOUT_EN:
- defined: a counter runs in MEM; after TMO_CYC cycles without mem_ack it sets mem_err=1 (sticky), drops the request, skips WB and goes to FETCH with pc+1;
- undefined: no counter, MEM waits indefinitely, mem_err is constant 0.

Verification
REQ-040 SHALL cover, after reset, instr 0x8A7F (LDI r10,0x7F) -> imm_en=1, imm_out=0x007F, sel_d=0xA, one reg_we pulse 2 cycles after accept, pc=1.
REQ-041 SHALL cover LOAD 0x1230 with mem_ack delayed 4 cycles -> mem_rd_req high exactly 4 cycles, op_code=0001, reg_we one cycle later, no overlap.
REQ-042 SHALL cover STORE 0x2045 with mem_ack after 1 cycle -> mem_wr_req 1 cycle, no reg_we, pc+1.
REQ-043 SHALL cover HALT 0xF000 followed by instr_valid held high -> halted=1, instr_ready stays 0; rst clears halted and pc=0.
REQ-044 SHALL cover rst asserted in the 2nd MEM cycle of a LOAD -> mem_rd_req=0, FETCH state and no reg_we afterwards.
REQ-045 SHALL cover, with CTRL_MEM_TIMEOUT_EN defined, a LOAD with no mem_ack -> mem_err=1 after 16 MEM cycles, no reg_we, next fetch at pc+1.

Source files
------------

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle instruction sequencer.
// Accepts one 16-bit instruction at a time, steps it through
// FETCH -> DECODE -> (MEM) -> (WB) -> FETCH, and drives register-file
// selectors, the write strobe and memory request lines. HALT is terminal
// until reset.
//
// Optional feature: define CTRL_MEM_TIMEOUT_EN to add a memory-wait
// timeout. After TMO_CYC MEM cycles without mem_ack the unit raises the
// sticky mem_err flag, abandons the access and moves on to pc+1. Without
// the macro MEM waits indefinitely and mem_err is tied low.

module ctrl_unit #(
    parameter int PC_W    = 8,
    parameter int TMO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [15:0]     instr_data,
    output logic            instr_ready,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      op_code,
    output logic            imm_en,
    output logic [15:0]     imm_out,
    output logic [3:0]      sel_d,
    output logic [3:0]      sel_a,
    output logic [3:0]      sel_b,
    output logic            reg_we,
    output logic            mem_rd_req,
    output logic            mem_wr_req,
    input  logic            mem_ack,
    output logic            halted,
    output logic            mem_err
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Instruction classes; every opcode not listed explicitly is an ALU op.
    typedef enum logic [2:0] {
        C_NOP   = 3'd0,
        C_LOAD  = 3'd1,
        C_STORE = 3'd2,
        C_LDI   = 3'd3,
        C_HALT  = 3'd4,
        C_ALU   = 3'd5
    } iclass_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_LDI   = 4'b1000;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    function automatic iclass_t classify(input logic [3:0] op);
        case (op)
            OP_NOP:   return C_NOP;
            OP_LOAD:  return C_LOAD;
            OP_STORE: return C_STORE;
            OP_LDI:   return C_LDI;
            OP_HALT:  return C_HALT;
            default:  return C_ALU;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              reg_we_q, reg_we_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              halted_q, halted_d;

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              mem_err_q, mem_err_d;
`endif

    iclass_t           iclass;
    logic [PC_W-1:0]   pc_inc;

    assign iclass = classify(ir_q[15:12]);
    // pc wraps modulo 2^PC_W by natural truncation of the sum.
    assign pc_inc = pc_q + PC_W'(1);

    // ------------------------------------------------------------------
    // Next-state and next-output logic for the sequencer
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        reg_we_d = 1'b0;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        halted_d = halted_q;
`ifdef CTRL_MEM_TIMEOUT_EN
        tmo_cnt_d = '0;
        mem_err_d = mem_err_q;
`endif

        case (state_q)
            S_FETCH: begin
                // instr_ready is high in this state, so valid alone is the handshake.
                if (instr_valid) begin
                    ir_d    = instr_data;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (iclass)
                    C_LOAD: begin
                        mem_rd_d = 1'b1;
                        state_d  = S_MEM;
                    end
                    C_STORE: begin
                        mem_wr_d = 1'b1;
                        state_d  = S_MEM;
                    end
                    C_LDI, C_ALU: begin
                        reg_we_d = 1'b1;
                        state_d  = S_WB;
                    end
                    C_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                if (mem_ack) begin
                    // Request drops on the same edge the acknowledge is sampled.
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (iclass == C_LOAD) begin
                        reg_we_d = 1'b1;
                        state_d  = S_WB;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
`ifdef CTRL_MEM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // Give up on the access: flag it, skip WB, move on.
                    mem_err_d = 1'b1;
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    pc_d      = pc_inc;
                    state_d   = S_FETCH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end

            S_WB: begin
                // reg_we_q is high for this single cycle; default clears it.
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers with synchronous reset; reset wins over any handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            reg_we_q <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            halted_q <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            reg_we_q <= reg_we_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            halted_q <= halted_d;
`ifdef CTRL_MEM_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from flops, so they are glitch-free and the
    // IR-derived fields hold still from DECODE until the next accept.
    // ------------------------------------------------------------------
    assign instr_ready = (state_q == S_FETCH);
    assign pc          = pc_q;
    assign op_code     = ir_q[15:12];
    assign imm_en      = (ir_q[15:12] == OP_LDI);
    assign imm_out     = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sel_d       = ir_q[11:8];
    assign sel_a       = ir_q[7:4];
    assign sel_b       = ir_q[3:0];
    assign reg_we      = reg_we_q;
    assign mem_rd_req  = mem_rd_q;
    assign mem_wr_req  = mem_wr_q;
    assign halted      = halted_q;

`ifdef CTRL_MEM_TIMEOUT_EN
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// Testbench for ctrl_unit: directed instructions with hand-computed
// expectations pushed into a scoreboard queue; a negedge monitor tracks each
// accepted instruction and compares when it retires (return to FETCH) or halts.

module tb_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        instr_ready;
    logic [7:0]  pc;
    logic [3:0]  op_code;
    logic        imm_en;
    logic [15:0] imm_out;
    logic [3:0]  sel_d, sel_a, sel_b;
    logic        reg_we;
    logic        mem_rd_req, mem_wr_req;
    logic        mem_ack;
    logic        halted;
    logic        mem_err;

    ctrl_unit #(.PC_W(8), .TMO_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .pc          (pc),
        .op_code     (op_code),
        .imm_en      (imm_en),
        .imm_out     (imm_out),
        .sel_d       (sel_d),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .reg_we      (reg_we),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_ack     (mem_ack),
        .halted      (halted),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;     // cycles from accept (cycle 0) to FETCH/HALT
        int          we;      // reg_we pulses expected
        int          we_idx;  // cycle index of the reg_we pulse
        int          rd;      // mem_rd_req high cycles
        int          wr;      // mem_wr_req high cycles
        logic [7:0]  pc;
        logic [3:0]  op;
        logic        imm_en;
        logic [15:0] imm;
        logic [3:0]  sd, sa, sbx;
        logic        halt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int lat, input int we, input int we_idx,
                                input int rd, input int wr, input logic [7:0] pc_e,
                                input logic [15:0] instr, input logic ie,
                                input logic [15:0] imm, input logic halt, input logic err);
        exp_t e;
        e.lat = lat; e.we = we; e.we_idx = we_idx; e.rd = rd; e.wr = wr;
        e.pc = pc_e; e.op = instr[15:12]; e.imm_en = ie; e.imm = imm;
        e.sd = instr[11:8]; e.sa = instr[7:4]; e.sbx = instr[3:0];
        e.halt = halt; e.err = err;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit          in_flight = 0;
    int          idx, we_cnt, we_at, rd_cnt, wr_cnt, overlap, unstable;
    int          stray_we = 0;
    logic [3:0]  c_op, c_sd, c_sa, c_sb;
    logic        c_ie;
    logic [15:0] c_imm;

    task automatic retire();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_retire", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("latency", idx, e.lat);
        check("reg_we_count", we_cnt, e.we);
        if (e.we != 0) check("reg_we_cycle", we_at, e.we_idx);
        check("mem_rd_cycles", rd_cnt, e.rd);
        check("mem_wr_cycles", wr_cnt, e.wr);
        check("we_req_overlap", overlap, 0);
        check("decode_unstable", unstable, 0);
        check("pc_after", pc, e.pc);
        check("op_code", c_op, e.op);
        check("imm_en", c_ie, e.imm_en);
        check("imm_out", c_imm, e.imm);
        check("sel_d", c_sd, e.sd);
        check("sel_a", c_sa, e.sa);
        check("sel_b", c_sb, e.sbx);
        check("halted", halted, e.halt);
        check("mem_err", mem_err, e.err);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_flight = 0;
        end else begin
            if (in_flight) begin
                idx++;
                if (instr_ready || halted) begin
                    retire();
                    in_flight = 0;
                end else begin
                    if (idx == 1) begin
                        c_op = op_code; c_ie = imm_en; c_imm = imm_out;
                        c_sd = sel_d; c_sa = sel_a; c_sb = sel_b;
                    end else if (op_code !== c_op || imm_en !== c_ie || imm_out !== c_imm ||
                                 sel_d !== c_sd || sel_a !== c_sa || sel_b !== c_sb) begin
                        unstable++;
                    end
                    if (reg_we) begin we_cnt++; we_at = idx; end
                    if (mem_rd_req) rd_cnt++;
                    if (mem_wr_req) wr_cnt++;
                    if (reg_we && (mem_rd_req || mem_wr_req)) overlap++;
                end
            end else if (reg_we) begin
                stray_we++;
            end
            if (instr_valid && instr_ready) begin
                in_flight = 1;
                idx = 0; we_cnt = 0; we_at = -1; rd_cnt = 0; wr_cnt = 0;
                overlap = 0; unstable = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change at posedge+1)
    // ------------------------------------------------------------------
    task automatic wait_fetch(input int max_cyc);
        int k = 0;
        while (!instr_ready && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        if (!instr_ready) check("wait_fetch_timeout", 0, 1);
    endtask

    task automatic send(input logic [15:0] w, input bit push, input exp_t e);
        wait_fetch(40);
        if (push) exp_q.push_back(e);
        instr_data  = w;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_req(input int max_cyc);
        int k = 0;
        while (!(mem_rd_req || mem_wr_req) && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        if (!(mem_rd_req || mem_wr_req)) check("wait_req_timeout", 0, 1);
    endtask

    // Ack in the n-th cycle the request is visible.
    task automatic ack_after(input int n);
        wait_req(10);
        repeat (n - 1) begin @(posedge clk); #1; end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    exp_t       dummy;
    logic [7:0] exp_pc;
    logic       exp_err;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_data = 16'h0000; mem_ack = 1'b0;
        exp_err = 1'b0;
        dummy = mk(0, 0, 0, 0, 0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_ready", instr_ready, 1);
        check("rst_pc", pc, 0);
        check("rst_op_code", op_code, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_mem_rd", mem_rd_req, 0);
        check("rst_mem_wr", mem_wr_req, 0);
        check("rst_halted", halted, 0);
        check("rst_mem_err", mem_err, 0);
        rst = 1'b0;
        exp_pc = 8'h00;

        // LDI r10,0x7F
        exp_pc = exp_pc + 8'd1;
        send(16'h8A7F, 1, mk(3, 1, 2, 0, 0, exp_pc, 16'h8A7F, 1'b1, 16'h007F, 1'b0, exp_err));
        // LOAD, ack in 4th MEM cycle
        exp_pc = exp_pc + 8'd1;
        send(16'h1230, 1, mk(7, 1, 6, 4, 0, exp_pc, 16'h1230, 1'b0, 16'h0030, 1'b0, exp_err));
        ack_after(4);
        // STORE, ack in 1st MEM cycle
        exp_pc = exp_pc + 8'd1;
        send(16'h2045, 1, mk(3, 0, 0, 0, 1, exp_pc, 16'h2045, 1'b0, 16'h0045, 1'b0, exp_err));
        ack_after(1);
        // ALU op with mem_ack held high throughout: must be ignored
        wait_fetch(40);
        mem_ack = 1'b1;
        exp_pc = exp_pc + 8'd1;
        send(16'h3ABC, 1, mk(3, 1, 2, 0, 0, exp_pc, 16'h3ABC, 1'b0, 16'hFFBC, 1'b0, exp_err));
        wait_fetch(40);
        mem_ack = 1'b0;
        // LDI with negative immediate
        exp_pc = exp_pc + 8'd1;
        send(16'h8180, 1, mk(3, 1, 2, 0, 0, exp_pc, 16'h8180, 1'b1, 16'hFF80, 1'b0, exp_err));
        // NOP
        exp_pc = exp_pc + 8'd1;
        send(16'h0000, 1, mk(2, 0, 0, 0, 0, exp_pc, 16'h0000, 1'b0, 16'h0000, 1'b0, exp_err));
        // 250 NOPs: pc 6 -> 256, wraps to 0
        for (int i = 0; i < 250; i++) begin
            exp_pc = exp_pc + 8'd1;
            send(16'h0000, 1, mk(2, 0, 0, 0, 0, exp_pc, 16'h0000, 1'b0, 16'h0000, 1'b0, exp_err));
        end
        wait_fetch(40);
        drain(40);
        check("pc_wrap", pc, 8'h00);

        // Reset in the 2nd MEM cycle of a LOAD, with a simultaneous ack
        send(16'h1230, 0, dummy);
        wait_req(10);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("abort_mem_rd", mem_rd_req, 0);
        check("abort_fetch", instr_ready, 1);
        check("abort_pc", pc, 0);
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("abort_no_reg_we", stray_we, 0);
        check("abort_still_fetch", instr_ready, 1);
        exp_pc = 8'h00;

        exp_pc = exp_pc + 8'd1;
        send(16'h0000, 1, mk(2, 0, 0, 0, 0, exp_pc, 16'h0000, 1'b0, 16'h0000, 1'b0, exp_err));

`ifdef CTRL_MEM_TIMEOUT_EN
        // LOAD that never gets an ack: 16 MEM cycles, then pc+1 and mem_err
        exp_err = 1'b1;
        exp_pc = exp_pc + 8'd1;
        send(16'h1230, 1, mk(18, 0, 0, 16, 0, exp_pc, 16'h1230, 1'b0, 16'h0030, 1'b0, exp_err));
        wait_fetch(40);
        check("tmo_mem_err", mem_err, 1);
        check("tmo_mem_rd_dropped", mem_rd_req, 0);
`endif

        // HALT with instr_valid held high afterwards
        send(16'hF000, 1, mk(2, 0, 0, 0, 0, exp_pc, 16'hF000, 1'b0, 16'h0000, 1'b1, exp_err));
        instr_valid = 1'b1;
        instr_data  = 16'h8A7F;
        repeat (6) begin
            @(posedge clk); #1;
            check("halt_instr_ready", instr_ready, 0);
        end
        check("halt_flag", halted, 1);
        check("halt_pc_hold", pc, exp_pc);
        drain(10);
        // Reset with instr_valid still high: reset wins, IR stays cleared
        rst = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("rst_halted_clear", halted, 0);
        check("rst_pc_clear", pc, 0);
        check("rst_ready_back", instr_ready, 1);
        check("rst_ir_clear", op_code, 0);
        check("rst_mem_err_clear", mem_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("final_no_stray_we", stray_we, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
